// File: rtl/seed_mode_pkg.sv
// Shared types and constants for the SEED block-cipher mode controller.
package seed_mode_pkg;

   localparam int BLK_W_DEFAULT = 128;

   localparam logic ENC = 1'b0;
   localparam logic DEC = 1'b1;

   typedef enum logic [1:0] {
      MODE_ECB  = 2'b00,
      MODE_CBC  = 2'b01,
      MODE_CTR  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEY_LOAD,
      ST_KEY_WAIT,
      ST_READY,
      ST_ISSUE,
      ST_WAIT,
      ST_HOLD
   } state_e;

endpackage

// File: rtl/seed_mode_chain.sv
// Chaining datapath: holds the IV/counter register and the mode-dependent
// pre-core and post-core XOR muxes.
module seed_mode_chain
   import seed_mode_pkg::*;
#(
   parameter int BLK_W = BLK_W_DEFAULT,
   parameter int CTR_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       mode,
   input  logic             encdec,
   input  logic             iv_load,
   input  logic [BLK_W-1:0] iv,
   input  logic             chain_update,
   input  logic [BLK_W-1:0] blk_in,
   input  logic [BLK_W-1:0] blk,
   input  logic [BLK_W-1:0] core_out,
   output logic [BLK_W-1:0] pre_data,
   output logic [BLK_W-1:0] post_data
);

   localparam logic [BLK_W-1:0] CTR_MASK = {BLK_W{1'b1}} >> (BLK_W - CTR_W);
   localparam logic [BLK_W-1:0] ONE      = BLK_W'(1);

   logic [BLK_W-1:0] chain_q;
   logic [BLK_W-1:0] chain_d;
   logic [BLK_W-1:0] chain_inc;
   mode_e            mode_sel;

   assign mode_sel = mode_e'(mode);

   // Only the low CTR_W bits count; the carry out of the field is dropped.
   assign chain_inc = (chain_q & ~CTR_MASK) | ((chain_q + ONE) & CTR_MASK);

   always_comb begin
      pre_data = blk_in;
      case (mode_sel)
         MODE_CBC: pre_data = (encdec == ENC) ? (blk_in ^ chain_q) : blk_in;
         MODE_CTR: pre_data = chain_q;
         default:  pre_data = blk_in;
      endcase
   end

   always_comb begin
      post_data = core_out;
      case (mode_sel)
         MODE_CBC: post_data = (encdec == ENC) ? core_out : (core_out ^ chain_q);
         MODE_CTR: post_data = blk ^ core_out;
         default:  post_data = core_out;
      endcase
   end

   always_comb begin
      chain_d = chain_q;
      if (iv_load) begin
         chain_d = iv;
      end else if (chain_update) begin
         case (mode_sel)
            MODE_CBC: chain_d = (encdec == ENC) ? core_out : blk;
            MODE_CTR: chain_d = chain_inc;
            default:  chain_d = chain_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

endmodule

// File: rtl/seed_mode_ctrl.sv
// ECB/CBC/CTR mode controller between a valid/ready block stream and the
// pulse-handshake SEED core; one block in flight, one-block output register.
module seed_mode_ctrl
   import seed_mode_pkg::*;
#(
   parameter int BLK_W = BLK_W_DEFAULT,
   parameter int CTR_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [1:0]       cfg_mode,
   input  logic             cfg_encdec,
   input  logic [BLK_W-1:0] cfg_key,
   input  logic [BLK_W-1:0] cfg_iv,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             cfg_err,
   output logic [BLK_W-1:0] core_data_in,
   output logic             core_data_rdy,
   output logic             core_key_rdy,
   output logic             core_EncDec,
   input  logic [BLK_W-1:0] core_data_out,
   input  logic             core_data_valid,
   input  logic             core_key_valid,
   input  logic             core_busy
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic             encdec_q, encdec_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic [BLK_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             cfg_err_q, cfg_err_d;
   logic [BLK_W-1:0] core_data_in_q, core_data_in_d;
   logic             core_data_rdy_q, core_data_rdy_d;
   logic             core_key_rdy_q, core_key_rdy_d;
   logic             core_encdec_q, core_encdec_d;

   logic             iv_load;
   logic             chain_update;
   logic [BLK_W-1:0] pre_data;
   logic [BLK_W-1:0] post_data;

   seed_mode_chain #(
      .BLK_W (BLK_W),
      .CTR_W (CTR_W)
   ) u_chain (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode_q),
      .encdec       (encdec_q),
      .iv_load      (iv_load),
      .iv           (cfg_iv),
      .chain_update (chain_update),
      .blk_in       (in_data),
      .blk          (blk_q),
      .core_out     (core_data_out),
      .pre_data     (pre_data),
      .post_data    (post_data)
   );

   // READY implies no block in flight and an empty output register.
   assign in_ready  = (state_q == ST_READY);
   assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_READY);

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      encdec_d        = encdec_q;
      blk_d           = blk_q;
      out_data_d      = out_data_q;
      out_valid_d     = out_valid_q;
      cfg_err_d       = cfg_err_q;
      core_data_in_d  = core_data_in_q;
      core_data_rdy_d = 1'b0;
      core_key_rdy_d  = 1'b0;
      core_encdec_d   = core_encdec_q;
      iv_load         = 1'b0;
      chain_update    = 1'b0;

      case (state_q)
         // Configuration takes priority over a simultaneous input block.
         ST_IDLE, ST_READY: begin
            if (cfg_valid) begin
               if (mode_e'(cfg_mode) == MODE_RSVD) begin
                  cfg_err_d = 1'b1;
               end else begin
                  cfg_err_d      = 1'b0;
                  mode_d         = mode_e'(cfg_mode);
                  encdec_d       = cfg_encdec;
                  iv_load        = 1'b1;
                  core_data_in_d = cfg_key;
                  core_key_rdy_d = 1'b1;
                  core_encdec_d  = (mode_e'(cfg_mode) == MODE_CTR) ? ENC : cfg_encdec;
                  state_d        = ST_KEY_LOAD;
               end
            end else if ((state_q == ST_READY) && in_valid) begin
               blk_d           = in_data;
               core_data_in_d  = pre_data;
               core_data_rdy_d = 1'b1;
               state_d         = ST_ISSUE;
            end
         end
         ST_KEY_LOAD: state_d = ST_KEY_WAIT;
         ST_KEY_WAIT: begin
            if (core_key_valid && !core_busy) begin
               state_d = ST_READY;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (core_data_valid) begin
               out_data_d   = post_data;
               out_valid_d  = 1'b1;
               chain_update = 1'b1;
               state_d      = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_READY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         mode_q          <= MODE_ECB;
         encdec_q        <= ENC;
         blk_q           <= '0;
         out_data_q      <= '0;
         out_valid_q     <= 1'b0;
         cfg_err_q       <= 1'b0;
         core_data_in_q  <= '0;
         core_data_rdy_q <= 1'b0;
         core_key_rdy_q  <= 1'b0;
         core_encdec_q   <= ENC;
      end else begin
         state_q         <= state_d;
         mode_q          <= mode_d;
         encdec_q        <= encdec_d;
         blk_q           <= blk_d;
         out_data_q      <= out_data_d;
         out_valid_q     <= out_valid_d;
         cfg_err_q       <= cfg_err_d;
         core_data_in_q  <= core_data_in_d;
         core_data_rdy_q <= core_data_rdy_d;
         core_key_rdy_q  <= core_key_rdy_d;
         core_encdec_q   <= core_encdec_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign cfg_err       = cfg_err_q;
   assign core_data_in  = core_data_in_q;
   assign core_data_rdy = core_data_rdy_q;
   assign core_key_rdy  = core_key_rdy_q;
   assign core_EncDec   = core_encdec_q;

endmodule

// File: tb/tb_seed_mode_ctrl.sv
// Randomized bench for seed_mode_ctrl with a stand-in core (invertible toy
// cipher) and a block-level ECB/CBC/CTR reference model.
module tb_seed_mode_ctrl;

   localparam int BLK_W    = 128;
   localparam int CTR_W    = 32;
   localparam int KEY_LAT  = 3;
   localparam int DATA_LAT = 4;
   localparam int TIMEOUT  = 60;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_valid, cfg_ready;
   logic [1:0]       cfg_mode;
   logic             cfg_encdec;
   logic [BLK_W-1:0] cfg_key, cfg_iv;
   logic             in_valid, in_ready;
   logic [BLK_W-1:0] in_data;
   logic             out_valid, out_ready;
   logic [BLK_W-1:0] out_data;
   logic             cfg_err;
   logic [BLK_W-1:0] core_data_in;
   logic             core_data_rdy, core_key_rdy, core_EncDec;
   logic [BLK_W-1:0] core_data_out;
   logic             core_data_valid, core_key_valid, core_busy;

   int checks      = 0;
   int failures    = 0;
   int key_pulses  = 0;
   int data_pulses = 0;
   int out_cycles  = 0;
   logic inject_valid = 1'b0;

   int               m_mode;
   logic             m_dir;
   logic [BLK_W-1:0] m_key;
   logic [BLK_W-1:0] m_chain;
   bit               m_ready = 1'b0;
   logic [BLK_W-1:0] last_core_in;

   always #5 clk = ~clk;

   seed_mode_ctrl #(.BLK_W(BLK_W), .CTR_W(CTR_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_mode        (cfg_mode),
      .cfg_encdec      (cfg_encdec),
      .cfg_key         (cfg_key),
      .cfg_iv          (cfg_iv),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .cfg_err         (cfg_err),
      .core_data_in    (core_data_in),
      .core_data_rdy   (core_data_rdy),
      .core_key_rdy    (core_key_rdy),
      .core_EncDec     (core_EncDec),
      .core_data_out   (core_data_out),
      .core_data_valid (core_data_valid),
      .core_key_valid  (core_key_valid),
      .core_busy       (core_busy)
   );

   function automatic logic [BLK_W-1:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [BLK_W-1:0] toy_enc(input logic [BLK_W-1:0] x, input logic [BLK_W-1:0] k);
      logic [BLK_W-1:0] t;
      t = x ^ k;
      return {t[BLK_W-14:0], t[BLK_W-1:BLK_W-13]};
   endfunction

   function automatic logic [BLK_W-1:0] toy_dec(input logic [BLK_W-1:0] y, input logic [BLK_W-1:0] k);
      return {y[12:0], y[BLK_W-1:13]} ^ k;
   endfunction

   // Stand-in core: key expansion and block cipher with fixed latencies;
   // direction is captured at key load, as in the real core.
   logic [BLK_W-1:0] core_key;
   logic             core_dir;
   int               core_cnt;
   logic             core_op;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         core_data_valid <= 1'b0;
         core_key_valid  <= 1'b0;
         core_busy       <= 1'b0;
         core_data_out   <= '0;
         core_cnt        <= 0;
         core_op         <= 1'b0;
         core_key        <= '0;
         core_dir        <= 1'b0;
      end else begin
         core_data_valid <= inject_valid;
         if (core_key_rdy) begin
            core_key       <= core_data_in;
            core_dir       <= core_EncDec;
            core_key_valid <= 1'b0;
            core_busy      <= 1'b1;
            core_cnt       <= KEY_LAT;
            core_op        <= 1'b0;
         end else if (core_data_rdy) begin
            core_busy     <= 1'b1;
            core_cnt      <= DATA_LAT;
            core_op       <= 1'b1;
            core_data_out <= core_dir ? toy_dec(core_data_in, core_key) : toy_enc(core_data_in, core_key);
         end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
               core_busy <= 1'b0;
               if (core_op) core_data_valid <= 1'b1;
               else         core_key_valid  <= 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (core_key_rdy)  key_pulses++;
         if (core_data_rdy) data_pulses++;
         if (out_valid)     out_cycles++;
      end
   end

   task automatic checkOutput(input string tag, input logic [BLK_W-1:0] got, input logic [BLK_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Block-level mode semantics, independent of how the controller sequences them.
   task automatic modelBlock(input logic [BLK_W-1:0] blk, output logic [BLK_W-1:0] core_in,
                             output logic [BLK_W-1:0] res);
      case (m_mode)
         1: begin
            if (!m_dir) begin
               core_in = blk ^ m_chain;
               res     = toy_enc(core_in, m_key);
               m_chain = res;
            end else begin
               core_in = blk;
               res     = toy_dec(blk, m_key) ^ m_chain;
               m_chain = blk;
            end
         end
         2: begin
            core_in = m_chain;
            res     = blk ^ toy_enc(m_chain, m_key);
            m_chain[CTR_W-1:0] = m_chain[CTR_W-1:0] + 1;
         end
         default: begin
            core_in = blk;
            res     = m_dir ? toy_dec(blk, m_key) : toy_enc(blk, m_key);
         end
      endcase
   endtask

   task automatic doCfg(input int mode, input logic dir, input logic [BLK_W-1:0] key,
                        input logic [BLK_W-1:0] iv, input bit with_in);
      int kp0, dp0, n;
      logic [1:0] mode2;
      mode2      = 2'(mode);
      cfg_mode   = mode2;
      cfg_encdec = dir;
      cfg_key    = key;
      cfg_iv     = iv;
      cfg_valid  = 1'b1;
      in_valid   = with_in;
      in_data    = rand_blk();
      n = 0;
      while (!cfg_ready && n < TIMEOUT) begin @(negedge clk); n++; end
      checkOutput("cfg_ready", cfg_ready, 1);
      kp0 = key_pulses;
      dp0 = data_pulses;
      @(negedge clk);
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      if (mode != 3) begin
         checkOutput("key_dir", core_EncDec, (mode == 2) ? 1'b0 : dir);
         n = 0;
         while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
         checkOutput("key_ready", in_ready, 1);
         checkOutput("key_pulse_once", key_pulses - kp0, 1);
         checkOutput("cfg_err_clear", cfg_err, 0);
         m_mode  = mode;
         m_dir   = dir;
         m_key   = key;
         m_chain = iv;
         m_ready = 1'b1;
      end else begin
         repeat (3) @(negedge clk);
         checkOutput("rsvd_err", cfg_err, 1);
         checkOutput("rsvd_no_key", key_pulses - kp0, 0);
         checkOutput("rsvd_state", in_ready, m_ready);
      end
      checkOutput("cfg_no_data", data_pulses - dp0, 0);
   endtask

   task automatic applyStimulus(input logic [BLK_W-1:0] blk, input int hold, output logic [BLK_W-1:0] res_got);
      logic [BLK_W-1:0] exp_in, exp_out;
      int dp0, n;
      modelBlock(blk, exp_in, exp_out);
      in_valid = 1'b1;
      in_data  = blk;
      n = 0;
      while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
      checkOutput("in_ready", in_ready, 1);
      dp0 = data_pulses;
      @(negedge clk);
      in_valid = 1'b0;
      checkOutput("data_rdy_lat", core_data_rdy, 1);
      checkOutput("core_data_in", core_data_in, exp_in);
      checkOutput("core_dir", core_EncDec, (m_mode == 2) ? 1'b0 : m_dir);
      last_core_in = core_data_in;
      n = 0;
      while (!out_valid && n < TIMEOUT) begin @(negedge clk); n++; end
      checkOutput("out_valid", out_valid, 1);
      checkOutput("out_data", out_data, exp_out);
      res_got = out_data;
      in_valid = (hold > 0);
      in_data  = rand_blk();
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_data", out_data, exp_out);
         checkOutput("hold_in_ready", in_ready, 0);
      end
      checkOutput("one_data_rdy", data_pulses - dp0, 1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("out_release", out_valid, 0);
   endtask

   initial begin
      logic [BLK_W-1:0] key, iv, p1, p2, c1, c2, r, scratch;
      int oc0, n;

      rst = 1'b1;
      cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_encdec = 1'b0; cfg_key = '0; cfg_iv = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_core_in", core_data_in, 0);
      checkOutput("rst_strobes", {core_data_rdy, core_key_rdy, core_EncDec}, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_cfg_err", cfg_err, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] reserved mode from IDLE");
      doCfg(3, 1'b0, rand_blk(), rand_blk(), 1'b0);

      $display("[TB] ECB encrypt/decrypt, long backpressure");
      key = rand_blk();
      p1  = rand_blk();
      doCfg(0, 1'b0, key, rand_blk(), 1'b0);
      applyStimulus(p1, 20, c1);
      doCfg(0, 1'b1, key, rand_blk(), 1'b0);
      applyStimulus(c1, 1, r);
      checkOutput("ecb_roundtrip", r, p1);

      $display("[TB] CBC two-block round trip");
      key = rand_blk(); iv = rand_blk(); p1 = rand_blk(); p2 = rand_blk();
      doCfg(1, 1'b0, key, iv, 1'b0);
      applyStimulus(p1, 0, c1);
      applyStimulus(p2, 2, c2);
      doCfg(1, 1'b1, key, iv, 1'b0);
      applyStimulus(c1, 0, r);
      checkOutput("cbc_rt1", r, p1);
      applyStimulus(c2, 0, r);
      checkOutput("cbc_rt2", r, p2);

      $display("[TB] CTR counter wrap");
      key = rand_blk(); iv = rand_blk(); iv[31:0] = 32'hFFFF_FFFF;
      p1 = rand_blk(); p2 = rand_blk();
      doCfg(2, 1'b0, key, iv, 1'b0);
      applyStimulus(p1, 0, c1);
      applyStimulus(p2, 0, c2);
      checkOutput("ctr_wrap_low", last_core_in[31:0], 0);
      checkOutput("ctr_wrap_high", last_core_in[BLK_W-1:32], iv[BLK_W-1:32]);
      doCfg(2, 1'b1, key, iv, 1'b0);
      applyStimulus(c1, 0, r);
      checkOutput("ctr_rt1", r, p1);
      applyStimulus(c2, 0, r);
      checkOutput("ctr_rt2", r, p2);

      $display("[TB] reserved cfg with input in READY, stray data_valid");
      doCfg(3, 1'b1, rand_blk(), rand_blk(), 1'b1);
      oc0 = out_cycles;
      inject_valid = 1'b1;
      @(negedge clk);
      inject_valid = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("stray_valid", out_cycles - oc0, 0);
      checkOutput("stray_ready", in_ready, 1);
      applyStimulus(rand_blk(), 1, scratch);

      $display("[TB] randomized sessions");
      for (int s = 0; s < 10; s++) begin
         int mode;
         mode = int'($urandom_range(0, 3));
         iv = rand_blk();
         if ($urandom_range(0, 1) == 1) iv[31:0] = 32'hFFFF_FFFE;
         doCfg(mode, 1'($urandom_range(0, 1)), rand_blk(), iv, bit'($urandom_range(0, 1)));
         if (m_ready) begin
            for (int b = 0; b < int'($urandom_range(2, 5)); b++) begin
               applyStimulus(rand_blk(), int'($urandom_range(0, 4)), scratch);
            end
         end
      end

      $display("[TB] reset during WAIT");
      doCfg(0, 1'b0, rand_blk(), rand_blk(), 1'b0);
      in_valid = 1'b1;
      in_data  = rand_blk();
      n = 0;
      while (!in_ready && n < TIMEOUT) begin @(negedge clk); n++; end
      checkOutput("abort_in_ready", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_out_data", out_data, 0);
      checkOutput("abort_core_in", core_data_in, 0);
      checkOutput("abort_strobes", {core_data_rdy, core_key_rdy, core_EncDec}, 0);
      checkOutput("abort_in_ready_low", in_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      m_ready = 1'b0;
      oc0 = out_cycles;
      repeat (DATA_LAT + 8) @(negedge clk);
      checkOutput("abort_no_out", out_cycles - oc0, 0);
      checkOutput("abort_idle", in_ready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
